// File: rtl/stdp_pkg.sv
// rtl/stdp_pkg.sv - shared types and constants for the STDP update controller
//
// Purpose : FSM state encoding and update-sign constants used by
//           stdp_update_ctrl and its testbench.
// Ports   : none (package).
package stdp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    APPLY = 2'd2
  } stdp_state_e;

  localparam logic SIGN_LTP = 1'b1;  // potentiation (pre before post)
  localparam logic SIGN_LTD = 1'b0;  // depression (post before pre)

endpackage

// File: rtl/spike_timer.sv
// rtl/spike_timer.sv - saturating time-since-spike counter with seen flag
//
// Purpose : Tracks how many cycles ago a neuron last spiked and whether
//           that spike is still available for pairing.
// Ports   : clk, rst_n    clock and synchronous active-low reset
//           spike         1-cycle spike pulse; restarts the count, sets seen
//           clear         drops the seen flag (pairing consumed / cancelled)
//           elapsed       cycle distance from the last spike to the current
//                         cycle, saturating at 2^T_WIDTH-1
//           seen          a spike has occurred and not yet been consumed
module spike_timer #(
  parameter int unsigned T_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spike,
  input  logic               clear,
  output logic [T_WIDTH-1:0] elapsed,
  output logic               seen
);

  localparam logic [T_WIDTH-1:0] T_MAX = '1;

  logic [T_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= T_MAX;
      seen <= 1'b0;
    end else if (spike) begin
      cnt  <= '0;
      // A spike coinciding with a clear (simultaneous pre/post) is not kept.
      seen <= ~clear;
    end else begin
      if (cnt != T_MAX) cnt <= cnt + 1'b1;
      if (clear) seen <= 1'b0;
    end
  end

  // cnt is 0 in the cycle after the spike, so the cycle distance seen by a
  // partner spike is one more than the stored count.
  assign elapsed = (cnt == T_MAX) ? T_MAX : cnt + 1'b1;

endmodule

// File: rtl/stdp_update_ctrl.sv
// rtl/stdp_update_ctrl.sv - pair-based STDP weight update controller
//
// Purpose : Timestamps pre/post spikes, detects pairings inside the learning
//           window and applies a linearly decaying, saturating weight delta.
// Config  : STDP_WEIGHT_LOAD_EN adds a direct weight-load port pair.
// Ports   : clk, rst_n     clock and synchronous active-low reset
//           pre_spike      presynaptic spike pulse
//           post_spike     postsynaptic spike pulse
//           learn_en       allow pairings to start updates
//           w_load         (STDP_WEIGHT_LOAD_EN) load weight next edge
//           w_load_val     (STDP_WEIGHT_LOAD_EN) value to load
//           weight         current synaptic weight
//           update_valid   1-cycle pulse when weight has just changed
//           update_sign    1 potentiation, 0 depression
//           time_diff      dt of the most recent accepted pairing
//           busy           FSM not idle
module stdp_update_ctrl
  import stdp_pkg::*;
#(
  parameter int unsigned W_WIDTH = 8,
  parameter int unsigned W_INIT  = 64,
  parameter int unsigned T_WIDTH = 4,
  parameter int unsigned WINDOW  = 12,
  parameter int unsigned A_PLUS  = 8,
  parameter int unsigned A_MINUS = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pre_spike,
  input  logic               post_spike,
  input  logic               learn_en,
`ifdef STDP_WEIGHT_LOAD_EN
  input  logic               w_load,
  input  logic [W_WIDTH-1:0] w_load_val,
`endif
  output logic [W_WIDTH-1:0] weight,
  output logic               update_valid,
  output logic               update_sign,
  output logic [T_WIDTH-1:0] time_diff,
  output logic               busy
);

  localparam logic [T_WIDTH-1:0] WIN_T = T_WIDTH'(WINDOW);

  stdp_state_e        state, state_nxt;
  logic [T_WIDTH-1:0] t_pre, t_post;
  logic               pre_seen, post_seen;
  logic               both_spike, ltp_trig, ltd_trig;
  logic               pre_clear, post_clear;
  logic               load;
  logic               latch_en, calc_en, apply_en;
  logic [W_WIDTH-1:0] delta_c, delta_q, weight_nxt;
  logic [W_WIDTH:0]   sum;
  int                 amp, dt_i;

`ifdef STDP_WEIGHT_LOAD_EN
  assign load = w_load;
`else
  assign load = 1'b0;
`endif

  // Pairing detection. Triggers consume the partner's seen flag whether or
  // not the FSM is free to act on them.
  assign both_spike = pre_spike & post_spike;
  assign ltp_trig   = post_spike & ~pre_spike & pre_seen  & (t_pre  < WIN_T);
  assign ltd_trig   = pre_spike  & ~post_spike & post_seen & (t_post < WIN_T);
  assign pre_clear  = both_spike | ltp_trig;
  assign post_clear = both_spike | ltd_trig;

  spike_timer #(.T_WIDTH(T_WIDTH)) u_pre_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .spike   (pre_spike),
    .clear   (pre_clear),
    .elapsed (t_pre),
    .seen    (pre_seen)
  );

  spike_timer #(.T_WIDTH(T_WIDTH)) u_post_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .spike   (post_spike),
    .clear   (post_clear),
    .elapsed (t_post),
    .seen    (post_seen)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (learn_en && (ltp_trig || ltd_trig)) state_nxt = CALC;
      CALC:    state_nxt = (delta_c == '0) ? IDLE : APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (load) state_nxt = IDLE;
  end

  // FSM outputs
  always_comb begin
    busy     = (state != IDLE);
    latch_en = (state == IDLE) && learn_en && (ltp_trig || ltd_trig) && !load;
    calc_en  = (state == CALC);
    apply_en = (state == APPLY) && !load;
  end

  // Linear decay: amplitude minus dt, floored at zero.
  always_comb begin
    amp     = (update_sign == SIGN_LTP) ? int'(A_PLUS) : int'(A_MINUS);
    dt_i    = int'(time_diff);
    delta_c = '0;
    if (dt_i < amp) delta_c = W_WIDTH'(amp - dt_i);
  end

  // Saturating weight arithmetic; the extra sum bit flags overflow.
  always_comb begin
    sum = {1'b0, weight} + {1'b0, delta_q};
    if (update_sign == SIGN_LTP)
      weight_nxt = sum[W_WIDTH] ? {W_WIDTH{1'b1}} : sum[W_WIDTH-1:0];
    else
      weight_nxt = (delta_q > weight) ? '0 : weight - delta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      weight       <= W_WIDTH'(W_INIT);
      update_valid <= 1'b0;
      update_sign  <= SIGN_LTD;
      time_diff    <= '0;
      delta_q      <= '0;
    end else begin
      update_valid <= 1'b0;
      if (latch_en) begin
        time_diff   <= ltp_trig ? t_pre : t_post;
        update_sign <= ltp_trig ? SIGN_LTP : SIGN_LTD;
      end
      if (calc_en) delta_q <= delta_c;
`ifdef STDP_WEIGHT_LOAD_EN
      if (w_load) begin
        weight <= w_load_val;
      end else
`endif
      if (apply_en) begin
        weight       <= weight_nxt;
        update_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stdp_update_ctrl.sv
// tb/tb_stdp_update_ctrl.sv - directed self-checking bench for stdp_update_ctrl
module tb_stdp_update_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pre = 1'b0, post = 1'b0, learn_en = 1'b1, sel_b = 1'b0;
  logic       pre_a, post_a, pre_b, post_b;
  logic [7:0] weight_a, weight_b;
  logic       valid_a, valid_b, sign_a, sign_b, busy_a, busy_b;
  logic [3:0] td_a, td_b;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  assign pre_a  = pre  & ~sel_b;
  assign post_a = post & ~sel_b;
  assign pre_b  = pre  &  sel_b;
  assign post_b = post &  sel_b;

  stdp_update_ctrl dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .pre_spike    (pre_a),
    .post_spike   (post_a),
    .learn_en     (learn_en),
    .weight       (weight_a),
    .update_valid (valid_a),
    .update_sign  (sign_a),
    .time_diff    (td_a),
    .busy         (busy_a)
  );

  stdp_update_ctrl #(.W_INIT(250)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .pre_spike    (pre_b),
    .post_spike   (post_b),
    .learn_en     (learn_en),
    .weight       (weight_b),
    .update_valid (valid_b),
    .update_sign  (sign_b),
    .time_diff    (td_b),
    .busy         (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive spikes for the current cycle, then move to the next cycle's
  // negedge where outputs are sampled.
  task automatic step(input logic p, input logic q);
    pre  = p;
    post = q;
    @(negedge clk);
    pre  = 1'b0;
    post = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0);
    step(0, 0);
    rst_n = 1'b1;
  endtask

  task automatic quiet_a(input string tag, input int n, input logic [7:0] w);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, busy_a, 0);
      check({tag, "_valid"}, valid_a, 0);
      step(0, 0);
    end
    check({tag, "_weight"}, weight_a, w);
  endtask

  initial begin
    @(negedge clk);
    sel_b = 1'b0;
    do_reset();
    check("rst_weight", weight_a, 64);
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_time_diff", td_a, 0);
    check("rst_sign", sign_a, 0);
    check("rst_weight_b", weight_b, 250);

    // pre at 0, post at 3: dt=3, delta=5
    step(1, 0); step(0, 0); step(0, 0); step(0, 1);
    check("ltp_busy_k1", busy_a, 1);
    check("ltp_dt", td_a, 3);
    check("ltp_sign_latched", sign_a, 1);
    step(0, 0);
    check("ltp_busy_k2", busy_a, 1);
    check("ltp_weight_k2", weight_a, 64);
    check("ltp_valid_k2", valid_a, 0);
    step(0, 0);
    check("ltp_weight", weight_a, 69);
    check("ltp_valid", valid_a, 1);
    check("ltp_sign", sign_a, 1);
    check("ltp_busy_k3", busy_a, 0);
    step(0, 0);
    check("ltp_valid_drop", valid_a, 0);

    // post at 0, pre at 2: dt=2, delta=4
    do_reset();
    step(0, 1); step(0, 0); step(1, 0);
    check("ltd_dt", td_a, 2);
    step(0, 0);
    step(0, 0);
    check("ltd_weight", weight_a, 60);
    check("ltd_sign", sign_a, 0);
    check("ltd_valid", valid_a, 1);

    // simultaneous spikes then post at 4: nothing happens
    do_reset();
    step(1, 1); step(0, 0); step(0, 0); step(0, 0); step(0, 1);
    quiet_a("simul", 6, 64);

    // pre at 13 cycles distance: outside window
    do_reset();
    step(1, 0);
    for (int i = 0; i < 12; i++) step(0, 0);
    step(0, 1);
    quiet_a("window", 6, 64);

    // learn_en low: pairing ignored
    do_reset();
    learn_en = 1'b0;
    step(1, 0); step(0, 0); step(0, 1);
    quiet_a("nolearn", 6, 64);
    learn_en = 1'b1;

    // trigger while busy is dropped: pre 0, post 1 (LTP +7), pre 2 (dropped LTD)
    do_reset();
    step(1, 0); step(0, 1); step(1, 0);
    check("drop_dt", td_a, 1);
    step(0, 0);
    check("drop_weight", weight_a, 71);
    check("drop_valid", valid_a, 1);
    step(0, 0);
    quiet_a("drop_after", 5, 71);

    // saturation on the W_INIT=250 instance
    sel_b = 1'b1;
    do_reset();
    step(1, 0); step(0, 1);
    check("sat_dt", td_b, 1);
    step(0, 0); step(0, 0);
    check("sat_weight", weight_b, 255);
    check("sat_valid", valid_b, 1);
    check("sat_a_untouched", weight_a, 64);
    for (int i = 0; i < 14; i++) step(0, 0);
    // dt=8 equals A_PLUS: delta 0, accepted but no pulse
    step(1, 0);
    for (int i = 0; i < 7; i++) step(0, 0);
    step(0, 1);
    check("zero_busy_calc", busy_b, 1);
    check("zero_dt", td_b, 8);
    step(0, 0);
    check("zero_busy_back", busy_b, 0);
    check("zero_valid_k2", valid_b, 0);
    step(0, 0);
    check("zero_valid_k3", valid_b, 0);
    check("zero_weight", weight_b, 255);
    sel_b = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
